decode_stage: RTL
=================

# decode_stage

Registered, flow-controlled successor to the combinational RV32I control decoder. It accepts one instruction plus PC per cycle over a valid/ready handshake, decodes it into the standard control bundle (mux selects, ALU op, RF/DMEM enables, branch/jump), flags illegal encodings, and optionally decodes RV32M. A 2-entry skid buffer sits between fetch and execute so backpressure never creates a combinational ready path.

## Interface
- XLEN, 32: PC width.
- ENABLE_M, 0: 1 = decode RV32M (funct7 = 7'b0000001, R_OPCODE) as legal; 0 = illegal.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries; has priority over every other event.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage can accept; registered, depends only on buffer occupancy.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute consumes entry.
- out_instr  out  32, out_pc  out  XLEN  pass-through of the accepted values.
- out_alu_imm_select, out_alu_pc_select, out_alu_mux1_select  out  1 each.
- out_alu_mux2_select  out  2; out_alu_op_select  out  4; out_rf_w_select  out  2.
- out_w_en_rf, out_wr_en_dmem, out_branch, out_jump  out  1 each.
- out_rw_mode  out  4  BYTE/HALFWORD/WORD.
- out_muldiv  out  1  RV32M op; out_alu_op_select = {1'b0, funct3[2:0]} in that case.
- out_illegal  out  1  unrecognised opcode/funct3/funct7 combination.

## Operation
- Decode is combinational on in_instr; the result is captured with in_pc/in_instr on an accepted transfer (in_valid && in_ready).
- The decode table covers RV32I base ops (R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC). The encodings come from the shared package.
- Arithmetic shift and SUB are selected by instr[30] for both R and I forms.
- An R-type funct7 other than 0000000, or 0100000 on ADD/SRL, is illegal unless it is 0000001 with ENABLE_M = 1.
- An illegal entry forces w_en_rf = wr_en_dmem = branch = jump = 0 and out_illegal = 1. It still flows through the buffer so execute can trap.
- FENCE/SYSTEM opcodes decode as a no-op: all enables are 0 and out_illegal = 0.
- Buffer states:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: out_valid = 1, in_ready = 1.
  - TWO: out_valid = 1, in_ready = 0.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without consume.
  - ONE→EMPTY on consume without accept.
  - ONE→ONE on both accept and consume.
  - TWO→ONE on consume.
- Ordering is strictly FIFO. out_* always reflects the head entry.
- flush: the next state is EMPTY and any same-cycle input is dropped. in_ready is 1 the following cycle.
- Reset: state EMPTY, out_valid 0, in_ready 1, all out_* control/data fields 0, out_rw_mode = WORD.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on out_* after edge N, if the buffer was EMPTY or the head is consumed at N.
- Throughput is 1 instruction/cycle when out_ready is held high.
- in_ready and out_valid are driven from flops only, with no combinational in→out path.
- Simultaneous accept and consume in ONE keeps occupancy at 1, and the new entry becomes the head next cycle.
- rst asserted mid-stream: identical to a flush plus zeroing of out_* fields on the next edge.
- While out_valid = 0, out_* fields hold their last values, except after reset/flush when they are 0. Verification must only check fields when out_valid = 1.

## Structure
- Shared package (common_library.vh) holds:
  - opcode and funct3 constants (including new FUNCT7_BASE, FUNCT7_ALT, FUNCT7_MULDIV);
  - the BYTE/HALFWORD/WORD encodings;
  - the ALU op encodings;
  - the packed control-bundle width.
- Sub-module decode_table: pure combinational instr → {control bundle, muldiv, illegal}, parameterised by ENABLE_M. The top level holds only the skid buffer and flush/reset logic.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3) with out_ready = 1: out_valid 1 cycle later; w_en_rf = 1, alu_imm_select = 0, alu_op_select = 0000, illegal = 0.
- Hold out_ready = 0 and offer 3 back-to-back instructions: first two accepted, in_ready = 0 on cycle 3. Release out_ready: entries drain in order, and the third is accepted the cycle after in_ready rises.
- MUL x1,x2,x3 (0x023100B3): with ENABLE_M = 0 → illegal = 1, w_en_rf = 0. With ENABLE_M = 1 → muldiv = 1, illegal = 0, alu_op_select = 0000.
- SRAI (0x4020D093) and SRLI (0x0020D093): alu_op_select differs and matches the package SRA/SRL codes.
- flush asserted in state TWO together with in_valid: next cycle out_valid = 0 and in_ready = 1; the flushed instruction never appears.
- SB x2,0(x1) (0x00208023): wr_en_dmem = 1, rw_mode = BYTE, w_en_rf = 0. Random valid/ready toggling over 1000 instructions: output sequence equals input sequence.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode encodings and the control bundle
// carried from decode to execute.
package decode_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [3:0] RW_BYTE = 4'b0001;
  localparam logic [3:0] RW_HALF = 4'b0011;
  localparam logic [3:0] RW_WORD = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] RFW_ALU = 2'd0;
  localparam logic [1:0] RFW_MEM = 2'd1;
  localparam logic [1:0] RFW_PC4 = 2'd2;

  localparam logic [1:0] MUX2_RS2 = 2'd0;
  localparam logic [1:0] MUX2_IMM = 2'd1;

  typedef struct packed {
    logic       alu_imm_select;
    logic       alu_pc_select;
    logic       alu_mux1_select;
    logic [1:0] alu_mux2_select;
    logic [3:0] alu_op_select;
    logic [1:0] rf_w_select;
    logic       w_en_rf;
    logic       wr_en_dmem;
    logic       branch;
    logic       jump;
    logic [3:0] rw_mode;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_RESET = '{
    rw_mode: RW_WORD,
    default: '0
  };

  function automatic logic [3:0] rw_mode_of(
    input logic [1:0] sz
  );
    logic [3:0] m;
    unique case (sz)
      2'b00:   m = RW_BYTE;
      2'b01:   m = RW_HALF;
      default: m = RW_WORD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decode_stage_table.sv
// Combinational RV32I(+M) decoder: instruction word to
// control bundle, with illegal-encoding detection.
module decode_table
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;
  logic       alt_ok;
  logic       unused_bits;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign alt_ok = (f3 == F3_ADD) || (f3 == F3_SR);

  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl  = CTRL_RESET;
    legal = 1'b1;
    unique case (1'b1)
      opc == OP_R: begin
        ctrl.w_en_rf       = 1'b1;
        ctrl.alu_op_select = {1'b0, f3};
        if (f7 == FUNCT7_ALT && alt_ok)
          ctrl.alu_op_select = {1'b1, f3};
        else if (f7 == FUNCT7_MULDIV && ENABLE_M)
          ctrl.muldiv = 1'b1;
        else if (f7 != FUNCT7_BASE)
          legal = 1'b0;
      end
      opc == OP_I: begin
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        ctrl.alu_op_select   =
          {(f3 == F3_SR) && instr[30], f3};
        // shift immediates carry funct7 in imm[11:5]
        if (f3 == F3_SLL && f7 != FUNCT7_BASE)
          legal = 1'b0;
        if (f3 == F3_SR && f7 != FUNCT7_BASE &&
            f7 != FUNCT7_ALT)
          legal = 1'b0;
      end
      opc == OP_LOAD: begin
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        ctrl.rf_w_select     = RFW_MEM;
        ctrl.rw_mode         = rw_mode_of(f3[1:0]);
        legal = (f3[1:0] != 2'b11) && (f3 != 3'b110);
      end
      opc == OP_STORE: begin
        ctrl.wr_en_dmem      = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        ctrl.rw_mode         = rw_mode_of(f3[1:0]);
        legal = !f3[2] && (f3[1:0] != 2'b11);
      end
      opc == OP_BRANCH: begin
        ctrl.branch          = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_pc_select   = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        legal = (f3[2:1] != 2'b01);
      end
      opc == OP_JAL: begin
        ctrl.jump            = 1'b1;
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_pc_select   = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        ctrl.rf_w_select     = RFW_PC4;
      end
      opc == OP_JALR: begin
        ctrl.jump            = 1'b1;
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
        ctrl.rf_w_select     = RFW_PC4;
        legal = (f3 == F3_ADD);
      end
      opc == OP_LUI: begin
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_mux1_select = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
      end
      opc == OP_AUIPC: begin
        ctrl.w_en_rf         = 1'b1;
        ctrl.alu_imm_select  = 1'b1;
        ctrl.alu_pc_select   = 1'b1;
        ctrl.alu_mux2_select = MUX2_IMM;
      end
      opc == OP_FENCE, opc == OP_SYSTEM: begin
        ctrl = CTRL_RESET;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl         = CTRL_RESET;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_table feeding a 2-entry
// skid buffer with flops-only in_ready/out_valid.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_alu_imm_select,
  output logic            out_alu_pc_select,
  output logic            out_alu_mux1_select,
  output logic [1:0]      out_alu_mux2_select,
  output logic [3:0]      out_alu_op_select,
  output logic [1:0]      out_rf_w_select,
  output logic            out_w_en_rf,
  output logic            out_wr_en_dmem,
  output logic            out_branch,
  output logic            out_jump,
  output logic [3:0]      out_rw_mode,
  output logic            out_muldiv,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctrl_t           ctrl;
  } entry_t;

  localparam entry_t CLEAR = '{
    pc:    '0,
    instr: '0,
    ctrl:  CTRL_RESET
  };

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  ctrl_t  in_ctrl;
  logic   in_ready_q, out_valid_q;
  logic   accept, consume;

  decode_table #(
    .ENABLE_M (ENABLE_M)
  ) u_table (
    .instr (in_instr),
    .ctrl  (in_ctrl)
  );

  assign in_entry = '{
    pc:    in_pc,
    instr: in_instr,
    ctrl:  in_ctrl
  };
  assign accept  = in_valid && in_ready_q;
  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d = ONE;
        head_d  = in_entry;
      end
      ONE: unique case ({accept, consume})
        2'b10: begin
          state_d = TWO;
          tail_d  = in_entry;
        end
        2'b01: state_d = EMPTY;
        2'b11: head_d = in_entry;
        default: ;
      endcase
      TWO: if (consume) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= CLEAR;
      tail_q      <= CLEAR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready            = in_ready_q;
  assign out_valid           = out_valid_q;
  assign out_instr           = head_q.instr;
  assign out_pc              = head_q.pc;
  assign out_alu_imm_select  = head_q.ctrl.alu_imm_select;
  assign out_alu_pc_select   = head_q.ctrl.alu_pc_select;
  assign out_alu_mux1_select = head_q.ctrl.alu_mux1_select;
  assign out_alu_mux2_select = head_q.ctrl.alu_mux2_select;
  assign out_alu_op_select   = head_q.ctrl.alu_op_select;
  assign out_rf_w_select     = head_q.ctrl.rf_w_select;
  assign out_w_en_rf         = head_q.ctrl.w_en_rf;
  assign out_wr_en_dmem      = head_q.ctrl.wr_en_dmem;
  assign out_branch          = head_q.ctrl.branch;
  assign out_jump            = head_q.ctrl.jump;
  assign out_rw_mode         = head_q.ctrl.rw_mode;
  assign out_muldiv          = head_q.ctrl.muldiv;
  assign out_illegal         = head_q.ctrl.illegal;

endmodule
